// File: rtl/klingon_pkg.sv
// rtl/klingon_pkg.sv - shared Klingon glyph table, widths and scan-decoder state encoding
package klingon_pkg;

    localparam int GLYPH_W = 7;
    localparam int NIB_W   = 4;

    // Segment order a..g in bits 6..0; all-off and all-on are deliberately absent.
    localparam logic [GLYPH_W-1:0] GLYPH [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h49, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        COLLECT = 1'b0,
        COMPARE = 1'b1
    } state_t;

endpackage

// File: rtl/klingon_glyph_lookup.sv
// rtl/klingon_glyph_lookup.sv - combinational segment pattern to nibble decode (blank output with KLINGON_SCAN_BLANK_EN)
module klingon_glyph_lookup
    import klingon_pkg::*;
(
    input  logic [GLYPH_W-1:0] seg_i,
    output logic [NIB_W-1:0]   nibble_o,
    output logic               illegal_o
`ifdef KLINGON_SCAN_BLANK_EN
    ,
    output logic               blank_o
`endif
);

    always_comb begin
        nibble_o  = '0;
        illegal_o = 1'b1;
`ifdef KLINGON_SCAN_BLANK_EN
        blank_o   = 1'b0;
        if (seg_i == '0) begin
            illegal_o = 1'b0;
            blank_o   = 1'b1;
        end
`endif
        for (int k = 0; k < 16; k++) begin
            if (seg_i == GLYPH[k]) begin
                nibble_o  = NIB_W'(k);
                illegal_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/klingon_scan_decoder.sv
// rtl/klingon_scan_decoder.sv - multiplexed 7-segment scan decoder with stable-frame emission (optional blank glyph via KLINGON_SCAN_BLANK_EN)
module klingon_scan_decoder
    import klingon_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sample_en,
    input  logic [GLYPH_W-1:0]          seg_in,
    input  logic [NUM_DIGITS-1:0]       dig_sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIB_W*NUM_DIGITS-1:0] frame_value,
    output logic                        frame_err,
    output logic [NUM_DIGITS-1:0]       err_mask,
    output logic                        sel_err
`ifdef KLINGON_SCAN_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]       blank_mask
`endif
);

    localparam int         FW     = NIB_W * NUM_DIGITS;
    localparam logic [3:0] SF_CNT = 4'(STABLE_FRAMES);

    logic [NIB_W-1:0] nib_w;
    logic             ill_w;
    logic             blk_w;

    klingon_glyph_lookup u_lookup (
        .seg_i     (seg_in),
        .nibble_o  (nib_w),
        .illegal_o (ill_w)
`ifdef KLINGON_SCAN_BLANK_EN
        ,
        .blank_o   (blk_w)
`endif
    );
`ifndef KLINGON_SCAN_BLANK_EN
    assign blk_w = 1'b0;
`endif

    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   cap_q, cap_d;
    logic [FW-1:0]           nib_q, nib_d, prev_nib_q, prev_nib_d, last_nib_q;
    logic [NUM_DIGITS-1:0]   ill_q, ill_d, prev_ill_q, prev_ill_d, last_ill_q;
    logic [NUM_DIGITS-1:0]   blk_q, blk_d, prev_blk_q, prev_blk_d, last_blk_q;
    logic [3:0]              stab_q, stab_d;
    logic                    emitted_q;
    logic                    out_valid_q;
    logic [FW-1:0]           frame_value_q;
    logic [NUM_DIGITS-1:0]   err_mask_q;
    logic                    sel_err_q;
`ifdef KLINGON_SCAN_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank_mask_q;
    assign blank_mask = blank_mask_q;
`endif

    logic sel_ok, same_frame, new_frame, emit;

    assign sel_ok      = $onehot(dig_sel);
    assign same_frame  = (nib_q == prev_nib_q) && (ill_q == prev_ill_q) && (blk_q == prev_blk_q);
    assign out_valid   = out_valid_q;
    assign frame_value = frame_value_q;
    assign err_mask    = err_mask_q;
    assign frame_err   = |err_mask_q;
    assign sel_err     = sel_err_q;

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        nib_d      = nib_q;
        ill_d      = ill_q;
        blk_d      = blk_q;
        stab_d     = stab_q;
        prev_nib_d = prev_nib_q;
        prev_ill_d = prev_ill_q;
        prev_blk_d = prev_blk_q;

        if (state_q == COMPARE) begin
            if (same_frame) begin
                if (stab_q < SF_CNT) stab_d = stab_q + 4'd1;
            end else begin
                stab_d     = 4'd1;
                prev_nib_d = nib_q;
                prev_ill_d = ill_q;
                prev_blk_d = blk_q;
            end
            cap_d   = '0;
            state_d = COLLECT;
        end

        // Applied after the COMPARE clear so a sample in that cycle opens the next frame.
        if (sample_en && sel_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i]) begin
                    nib_d[i*NIB_W +: NIB_W] = nib_w;
                    ill_d[i] = ill_w;
                    blk_d[i] = blk_w;
                    cap_d[i] = 1'b1;
                end
            end
        end

        if (state_q == COLLECT && cap_d == '1) state_d = COMPARE;
    end

    // Next-state stability is used so a frame stabilising in COMPARE loads the outputs at that same edge.
    assign new_frame = !emitted_q || (prev_nib_d != last_nib_q) ||
                       (prev_ill_d != last_ill_q) || (prev_blk_d != last_blk_q);
    assign emit      = !out_valid_q && (stab_d == SF_CNT) && new_frame;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= COLLECT;
            cap_q         <= '0;
            nib_q         <= '0;
            ill_q         <= '0;
            blk_q         <= '0;
            stab_q        <= '0;
            prev_nib_q    <= '0;
            prev_ill_q    <= '0;
            prev_blk_q    <= '0;
            last_nib_q    <= '0;
            last_ill_q    <= '0;
            last_blk_q    <= '0;
            emitted_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_value_q <= '0;
            err_mask_q    <= '0;
            sel_err_q     <= 1'b0;
`ifdef KLINGON_SCAN_BLANK_EN
            blank_mask_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            nib_q      <= nib_d;
            ill_q      <= ill_d;
            blk_q      <= blk_d;
            stab_q     <= stab_d;
            prev_nib_q <= prev_nib_d;
            prev_ill_q <= prev_ill_d;
            prev_blk_q <= prev_blk_d;

            if (sample_en && !sel_ok) sel_err_q <= 1'b1;

            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end else if (emit) begin
                out_valid_q   <= 1'b1;
                frame_value_q <= prev_nib_d;
                err_mask_q    <= prev_ill_d;
`ifdef KLINGON_SCAN_BLANK_EN
                blank_mask_q  <= prev_blk_d;
`endif
                emitted_q     <= 1'b1;
                last_nib_q    <= prev_nib_d;
                last_ill_q    <= prev_ill_d;
                last_blk_q    <= prev_blk_d;
            end
        end
    end

endmodule

// File: tb/tb_klingon_scan_decoder.sv
// tb/tb_klingon_scan_decoder.sv - self-checking bench for klingon_scan_decoder against a frame-level reference model
module tb_klingon_scan_decoder;

    localparam int N  = 4;
    localparam int SF = 2;

    logic           clk = 1'b0;
    logic           reset_n, sample_en, out_ready;
    logic [6:0]     seg_in;
    logic [N-1:0]   dig_sel;
    logic           out_valid, frame_err, sel_err;
    logic [4*N-1:0] frame_value;
    logic [N-1:0]   err_mask;
`ifdef KLINGON_SCAN_BLANK_EN
    logic [N-1:0]   blank_mask;
`endif

    always #5 clk = ~clk;

    klingon_scan_decoder #(.NUM_DIGITS(N), .STABLE_FRAMES(SF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_en   (sample_en),
        .seg_in      (seg_in),
        .dig_sel     (dig_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_value (frame_value),
        .frame_err   (frame_err),
        .err_mask    (err_mask),
        .sel_err     (sel_err)
`ifdef KLINGON_SCAN_BLANK_EN
        ,
        .blank_mask  (blank_mask)
`endif
    );

    // Encoder-side glyph set, written out independently of the design package.
    logic [6:0] g [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h49, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct packed {
        logic [N-1:0]   blk;
        logic [N-1:0]   ill;
        logic [4*N-1:0] nib;
    } frame_t;

    frame_t       slots, prev, last;
    logic [N-1:0] mask;
    int           cnt;
    bit           have_last;
    frame_t       exp_q[$];
    int           pushed, popped;
    int           checks, errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [6:0] s, output logic [3:0] n,
                                   output logic il, output logic bl);
        n  = 4'd0;
        il = 1'b1;
        bl = 1'b0;
`ifdef KLINGON_SCAN_BLANK_EN
        if (s == 7'h00) begin il = 1'b0; bl = 1'b1; end
`endif
        for (int k = 0; k < 16; k++)
            if (s == g[k]) begin n = k[3:0]; il = 1'b0; end
    endfunction

    function automatic void model_frame(input frame_t f);
        if (f == prev) begin
            if (cnt < SF) cnt++;
        end else begin
            cnt  = 1;
            prev = f;
        end
        if (cnt == SF && (!have_last || f != last)) begin
            exp_q.push_back(f);
            last      = f;
            have_last = 1'b1;
            pushed++;
        end
    endfunction

    function automatic void model_sample(input int d, input logic [6:0] s);
        logic [3:0] n;
        logic il, bl;
        decode(s, n, il, bl);
        slots.nib[d*4 +: 4] = n;
        slots.ill[d] = il;
        slots.blk[d] = bl;
        mask[d] = 1'b1;
        if (&mask) begin
            mask = '0;
            model_frame(slots);
        end
    endfunction

    function automatic void model_reset();
        slots     = '0;
        prev      = '0;
        last      = '0;
        mask      = '0;
        cnt       = 0;
        have_last = 1'b0;
        pushed   -= exp_q.size();
        exp_q.delete();
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic put(input int d, input logic [6:0] s);
        dig_sel    = '0;
        dig_sel[d] = 1'b1;
        seg_in     = s;
        sample_en  = 1'b1;
        @(posedge clk); #1;
        sample_en  = 1'b0;
        dig_sel    = '0;
        model_sample(d, s);
    endtask

    task automatic scan4(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
        put(0, a); put(1, b); put(2, c); put(3, d);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_value"}, 32'(frame_value), 32'd0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
        chk({tag, "_emask"}, 32'(err_mask), 32'd0);
        chk({tag, "_selerr"}, 32'(sel_err), 32'd0);
`ifdef KLINGON_SCAN_BLANK_EN
        chk({tag, "_bmask"}, 32'(blank_mask), 32'd0);
`endif
    endtask

    // Every handshake must deliver the oldest frame the model expects.
    always @(negedge clk) begin
        frame_t e;
        if (reset_n && out_valid && out_ready) begin
            chk("emit_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("hs_value", 32'(frame_value), 32'(e.nib));
                chk("hs_emask", 32'(err_mask), 32'(e.ill));
                chk("hs_ferr", 32'(frame_err), 32'(|e.ill));
`ifdef KLINGON_SCAN_BLANK_EN
                chk("hs_bmask", 32'(blank_mask), 32'(e.blk));
`endif
            end
            popped++;
        end
    end

    initial begin
        logic [6:0] cur [4];
        int r, start, d;

        checks = 0; errors = 0; pushed = 0; popped = 0;
        exp_q.delete();
        model_reset();
        reset_n = 1'b0; sample_en = 1'b0; seg_in = '0; dig_sel = '0; out_ready = 1'b1;
        #12;
        chk_zero_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // First stable frame and its two-cycle latency.
        scan4(g[1], g[2], g[3], g[4]);
        put(0, g[1]); put(1, g[2]); put(2, g[3]); put(3, g[4]);
        chk("lat_early", 32'(out_valid), 32'd0);
        idle(1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_value", 32'(frame_value), 32'h4321);
        chk("lat_ferr", 32'(frame_err), 32'd0);
        idle(1);
        chk("single_pulse", 32'(out_valid), 32'd0);

        repeat (5) scan4(g[1], g[2], g[3], g[4]);
        idle(3);
        chk("no_reemit", 32'(popped), 32'd1);
        scan4(g[1], g[2], g[9], g[4]);
        scan4(g[1], g[2], g[9], g[4]);
        idle(1);
        chk("chg_value", 32'(frame_value), 32'h4921);
        idle(2);
        chk("chg_emitted", 32'(popped), 32'd2);

        // Back-pressure: outputs hold until the consumer is ready.
        out_ready = 1'b0;
        scan4(g[5], g[6], g[7], g[8]);
        scan4(g[5], g[6], g[7], g[8]);
        for (int i = 0; i < 20 && !out_valid; i++) idle(1);
        chk("hold_arrive", 32'(out_valid), 32'd1);
        chk("hold_value0", 32'(frame_value), 32'h8765);
        for (int i = 0; i < 20; i++) begin
            idle(1);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_value", 32'(frame_value), 32'h8765);
        end
        out_ready = 1'b1;
        idle(1);
        chk("hold_drop", 32'(out_valid), 32'd0);
        chk("hold_popped", 32'(popped), 32'd3);

        // Illegal glyph on digit 1.
        scan4(g[1], 7'h7F, g[3], g[4]);
        scan4(g[1], 7'h7F, g[3], g[4]);
        idle(1);
        chk("ill_value", 32'(frame_value), 32'h4301);
        chk("ill_emask", 32'(err_mask), 32'b0010);
        chk("ill_ferr", 32'(frame_err), 32'd1);

        // All-off on digit 3.
        scan4(g[1], g[2], g[3], 7'h00);
        scan4(g[1], g[2], g[3], 7'h00);
        idle(1);
        chk("blank_value", 32'(frame_value), 32'h0321);
`ifdef KLINGON_SCAN_BLANK_EN
        chk("blank_emask", 32'(err_mask), 32'd0);
        chk("blank_ferr", 32'(frame_err), 32'd0);
        chk("blank_bmask", 32'(blank_mask), 32'b1000);
`else
        chk("blank_emask", 32'(err_mask), 32'b1000);
        chk("blank_ferr", 32'(frame_err), 32'd1);
`endif
        idle(2);

        // Randomised frames, scan order, gaps and slot overwrites.
        for (int f = 0; f < 40; f++) begin
            if (f == 0 || $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    r = int'($urandom_range(0, 15));
                    if (r < 12)      cur[i] = g[$urandom_range(0, 12)];
                    else if (r < 14) cur[i] = 7'($urandom);
                    else             cur[i] = 7'h00;
                end
            end
            start = int'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) begin
                d = (start + j) % 4;
                if (j < 3 && $urandom_range(0, 7) == 0) put(d, g[$urandom_range(0, 15)]);
                put(d, cur[d]);
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(4);
        chk("rand_all_emitted", 32'(popped), 32'(pushed));

        // Non-one-hot select is flagged and leaves the slots alone.
        chk("selerr_clear", 32'(sel_err), 32'd0);
        put(0, g[10]); put(1, g[11]);
        dig_sel = 4'b0110; seg_in = g[9]; sample_en = 1'b1;
        idle(1);
        sample_en = 1'b0; dig_sel = '0;
        chk("selerr_set", 32'(sel_err), 32'd1);
        put(2, g[12]); put(3, g[13]);
        out_ready = 1'b0;
        scan4(g[10], g[11], g[12], g[13]);
        idle(1);
        chk("selerr_valid", 32'(out_valid), 32'd1);
        chk("selerr_value", 32'(frame_value), 32'hDCBA);

        // Asynchronous reset in the middle of a frame with an emission pending.
        put(0, g[5]); put(1, g[6]);
        #2 reset_n = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        put(2, g[7]); put(3, g[7]);
        repeat (3) scan4(g[1], g[2], g[3], g[4]);
        idle(4);
        chk("post_reset_emitted", 32'(popped), 32'(pushed));
        chk("post_reset_selerr", 32'(sel_err), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
